// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: beat-serial front end for an iterative AES-128 core.
// Collects key/plaintext beats into 128-bit blocks, launches the core once per
// block, and streams the ciphertext back out. Supports CBC chaining with a
// loadable IV, key reuse across blocks, and a watchdog on a hung core.
module aes_stream_ctrl #(
    parameter int BUS_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    input  logic [BUS_W-1:0] in_key,
    input  logic             in_is_iv,
    input  logic             key_hold,
    input  logic             mode_cbc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             err,
    output logic             core_start,
    output logic [127:0]     core_key,
    output logic [127:0]     core_pt,
    input  logic             core_done,
    input  logic [127:0]     core_ct
);
    localparam int BEATS = 128 / BUS_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BEAT    = CW'(BEATS - 1);
    // err is registered, so the abort decision is taken one cycle early; this
    // places the err pulse exactly TIMEOUT cycles after the core_start pulse.
    localparam logic [TW-1:0] TIMER_EXPIRE = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   block_q, block_d;
    logic [127:0]   chain_q, chain_d;
    logic [127:0]   out_q, out_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           iv_q, iv_d;
    logic           hold_q, hold_d;
    logic           cbc_q, cbc_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           core_start_q, core_start_d;
    logic           err_q, err_d;

    // Sideband flags as seen by the current beat (live on beat 0, latched after)
    logic           iv_eff, hold_eff;

    // Next-state and datapath logic for the whole controller
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        block_d      = block_q;
        chain_d      = chain_q;
        out_d        = out_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        iv_d         = iv_q;
        hold_d       = hold_q;
        cbc_d        = cbc_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        core_start_d = 1'b0;
        err_d        = 1'b0;
        iv_eff       = (cnt_q == '0) ? in_is_iv : iv_q;
        hold_eff     = (cnt_q == '0) ? key_hold : hold_q;

        case (state_q)
            S_IDLE: begin
                state_d    = S_LOAD;
                in_ready_d = 1'b1;
            end
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    if (cnt_q == '0) begin
                        iv_d   = in_is_iv;
                        hold_d = key_hold;
                        cbc_d  = mode_cbc;
                    end
                    block_d = {block_q[127-BUS_W:0], in_data};
                    if (!hold_eff) begin
                        key_d = {key_q[127-BUS_W:0], in_key};
                    end
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d = '0;
                        if (iv_eff) begin
                            // IV blocks only seed the chain; stay ready for data
                            chain_d = block_d;
                        end else begin
                            state_d      = S_START;
                            in_ready_d   = 1'b0;
                            core_start_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A done arriving together with expiry takes priority
                if (core_done) begin
                    out_d       = core_ct;
                    state_d     = S_DRAIN;
                    out_valid_d = 1'b1;
                    if (cbc_q) begin
                        chain_d = core_ct;
                    end
                end else if (timer_q == TIMER_EXPIRE) begin
                    err_d      = 1'b1;
                    block_d    = '0;
                    state_d    = S_LOAD;
                    in_ready_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_d = out_q << BUS_W;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d       = '0;
                        state_d     = S_LOAD;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to zero/IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            block_q      <= '0;
            chain_q      <= '0;
            out_q        <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            iv_q         <= 1'b0;
            hold_q       <= 1'b0;
            cbc_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            block_q      <= block_d;
            chain_q      <= chain_d;
            out_q        <= out_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            iv_q         <= iv_d;
            hold_q       <= hold_d;
            cbc_q        <= cbc_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_q[127 -: BUS_W];
    assign err        = err_q;
    assign core_start = core_start_q;
    assign core_key   = key_q;
    // Block and chain are frozen from START through WAIT, so this stays stable
    assign core_pt    = block_q ^ (cbc_q ? chain_q : 128'h0);

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: behavioural AES-128 core (fixed latency) plus a
// block-level reference model tracking key and CBC chain.
module tb_aes_stream_ctrl;
    localparam int BW    = 8;
    localparam int TO    = 16;
    localparam int LAT   = 11;
    localparam int BEATS = 128 / BW;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic [BW-1:0] in_key = '0;
    logic          in_is_iv = 1'b0;
    logic          key_hold = 1'b0;
    logic          mode_cbc = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic          err;
    logic          core_start;
    logic [127:0]  core_key;
    logic [127:0]  core_pt;
    logic          core_done = 1'b0;
    logic [127:0]  core_ct = '0;

    aes_stream_ctrl #(.BUS_W(BW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .in_is_iv(in_is_iv), .key_hold(key_hold), .mode_cbc(mode_cbc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err), .core_start(core_start), .core_key(core_key), .core_pt(core_pt),
        .core_done(core_done), .core_ct(core_ct)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) begin
            tmp  = w[i/4];
            s[i] = pt[127-8*i -: 8] ^ tmp[31-8*(i%4) -: 8];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr+4*c] = t[rr+4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) begin
                tmp  = w[4*r + i/4];
                s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- behavioural core: fixed latency, optional hang/noise ----------------
    bit           hang = 1'b0;
    bit           spur = 1'b0;
    int           cm_cnt = 0;
    int           done_cyc = 0;
    logic [127:0] cm_key, cm_pt;

    always @(posedge clk) begin
        #1;
        core_done = 1'b0;
        if (rst) begin
            cm_cnt = 0;
        end else if (core_start) begin
            cm_cnt = LAT;
            cm_key = core_key;
            cm_pt  = core_pt;
        end else if (cm_cnt > 0) begin
            cm_cnt--;
            if (cm_cnt == 0 && !hang) begin
                core_done = 1'b1;
                core_ct   = aes128(cm_key, cm_pt);
                done_cyc  = cyc;
            end
        end else if (spur && !hang && $urandom_range(0, 7) == 0) begin
            core_done = 1'b1;
            core_ct   = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // ---------------- reference model state ----------------
    logic [127:0] m_key   = '0;
    logic [127:0] m_chain = '0;
    int           blk_no  = 0;

    task automatic do_block(input logic [127:0] pt, input logic [127:0] key,
                            input bit iv, input bit hold, input bit cbc,
                            input bit gaps, input bit bp,
                            input bit use_exp, input logic [127:0] exp_fixed,
                            input int abort_at, input bit hang_core);
        logic [127:0] eff_key, exp_pt, exp_ct;
        int  beat, guard, i, start_cyc;
        bit  tog, err_seen, pt_ok;
        eff_key = hold ? m_key : key;
        exp_pt  = pt ^ (cbc ? m_chain : 128'h0);
        exp_ct  = use_exp ? exp_fixed : aes128(eff_key, exp_pt);
        blk_no++;
        $display("block %0d: iv=%0b hold=%0b cbc=%0b gaps=%0b bp=%0b hang=%0b abort=%0d pt=%h",
                 blk_no, iv, hold, cbc, gaps, bp, hang_core, abort_at, pt);
        hang = hang_core;

        beat  = 0;
        guard = 0;
        while (beat < BEATS) begin
            @(negedge clk);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = pt[127-BW*beat -: BW];
            in_key   = key[127-BW*beat -: BW];
            in_is_iv = (beat == 0) ? iv   : 1'($urandom_range(0, 1));
            key_hold = (beat == 0) ? hold : 1'($urandom_range(0, 1));
            mode_cbc = (beat == 0) ? cbc  : 1'($urandom_range(0, 1));
            if (in_valid && in_ready) beat++;
            guard++;
            if (guard > 300) begin
                chk("in_accept_timeout", 128'(beat), 128'(BEATS));
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        m_key    = eff_key;

        if (iv) begin
            chk("iv_no_start", 128'(core_start), 128'(0));
            chk("iv_ready", 128'(in_ready), 128'(1));
            m_chain = pt;
            return;
        end

        chk("start_latency", 128'(core_start), 128'(1));
        chk("in_ready_low", 128'(in_ready), 128'(0));
        chk("core_pt", core_pt, exp_pt);
        chk("core_key", core_key, eff_key);
        start_cyc = cyc;

        if (hang_core) begin
            guard = 0;
            while (!err && guard < TO + 10) begin
                @(negedge clk);
                guard++;
            end
            chk("err_cycle", 128'(cyc - start_cyc), 128'(TO));
            chk("err_in_ready", 128'(in_ready), 128'(1));
            @(negedge clk);
            chk("err_one_cycle", 128'(err), 128'(0));
            chk("ready_after_err", 128'(in_ready), 128'(1));
            hang = 1'b0;
            return;
        end

        guard    = 0;
        err_seen = 1'b0;
        pt_ok    = 1'b1;
        while (!out_valid && guard < LAT + TO) begin
            if (core_pt !== exp_pt) pt_ok = 1'b0;
            @(negedge clk);
            guard++;
            if (err) err_seen = 1'b1;
        end
        chk("out_valid_seen", 128'(out_valid), 128'(1));
        chk("done_to_valid", 128'(cyc), 128'(done_cyc + 1));
        chk("no_err", 128'(err_seen), 128'(0));
        chk("pt_held", 128'(pt_ok), 128'(1));

        i     = 0;
        guard = 0;
        tog   = 1'b1;
        while (i < BEATS && guard < 400) begin
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_out_valid", 128'(out_valid), 128'(0));
                chk("abort_core_pt", core_pt, 128'h0);
                chk("abort_core_key", core_key, 128'h0);
                @(negedge clk);
                rst       = 1'b0;
                out_ready = 1'b0;
                m_key     = '0;
                m_chain   = '0;
                return;
            end
            chk("out_beat", 128'(out_data), 128'(exp_ct[127-BW*i -: BW]));
            chk("out_valid_hold", 128'(out_valid), 128'(1));
            out_ready = bp ? tog : 1'b1;
            tog = ~tog;
            if (out_valid && out_ready) i++;
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        chk("drain_beats", 128'(i), 128'(BEATS));
        chk("drain_end_valid", 128'(out_valid), 128'(0));
        chk("back_to_load", 128'(in_ready), 128'(1));
        if (cbc) m_chain = exp_ct;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] inv_v, b1, b2, b3, b4;
        for (int x = 0; x < 256; x++) begin
            inv_v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv_v = 8'(y);
            b1 = rl(inv_v); b2 = rl(b1); b3 = rl(b2); b4 = rl(b3);
            sbox[x] = inv_v ^ b1 ^ b2 ^ b3 ^ b4 ^ 8'h63;
        end

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_core_start", 128'(core_start), 128'(0));
        chk("rst_core_key", core_key, 128'h0);
        chk("rst_core_pt", core_pt, 128'h0);
        chk("rst_out_data", 128'(out_data), 128'(0));
        rst = 1'b0;

        // FIPS-197 vectors, ECB
        do_block(PT1, KEY1, 0, 0, 0, 0, 0, 1, CT1, -1, 0);
        do_block(PT2, KEY2, 0, 0, 0, 0, 0, 1, CT2, -1, 0);
        // CBC: zero IV, known block, then chained block reusing the key
        do_block(128'h0, KEY1, 1, 0, 0, 0, 0, 0, 128'h0, -1, 0);
        do_block(PT1, KEY1, 0, 0, 1, 0, 0, 1, CT1, -1, 0);
        do_block(CT1, 128'h0, 0, 1, 1, 0, 0, 0, 128'h0, -1, 0);
        // Backpressure and input gaps
        do_block(PT1, KEY1, 0, 0, 0, 1, 1, 1, CT1, -1, 0);
        // Core hang
        do_block({$urandom, $urandom, $urandom, $urandom}, KEY2, 0, 0, 0, 0, 0, 0, 128'h0, -1, 1);
        // Key kept across the timeout
        do_block(PT2, 128'h0, 0, 1, 0, 0, 0, 1, CT2, -1, 0);
        // Reset mid-drain, then fresh CBC block must see a zero chain
        do_block(PT1, KEY1, 0, 0, 0, 0, 0, 1, CT1, 5, 0);
        do_block(PT1, KEY1, 0, 0, 1, 0, 0, 1, CT1, -1, 0);

        // Randomized traffic with stray done pulses outside WAIT
        spur = 1'b1;
        for (int n = 0; n < 20; n++) begin
            do_block({$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom},
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 0, 128'h0, -1, 0);
        end
        spur = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
